multicycle_controller: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS controller. An FSM sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. Instruction fetch and data memory use request/acknowledge handshakes. A return-stack depth counter flags jsb/ret overflow and underflow, and a HALT state replaces the simulation-only stop. It sits between the instruction/data memories and the existing datapath, and drives the same control signal names.

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/instr_decoder.sv | 40 ++++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle controller: FSM states,
// pc_src selects, opcode prefixes, instruction classes and the decoded control bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_STACK  = 2'b10;

  localparam logic [1:0] OP_RTYPE  = 2'b00;
  localparam logic [1:0] OP_IMM    = 2'b01;
  localparam logic [2:0] OP_MEM    = 3'b100;
  localparam logic [2:0] OP_BRANCH = 3'b101;
  localparam logic [2:0] OP_SHIFT  = 3'b110;
  localparam logic [3:0] OP_JUMP   = 4'b1110;
  localparam logic [5:0] OP_RET    = 6'b111100;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  typedef enum logic [3:0] {
    CL_ALU, CL_SHIFT, CL_LOAD, CL_STORE, CL_BRANCH,
    CL_JUMP, CL_JSB, CL_RET, CL_HALT, CL_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic [2:0] acode;
    logic [1:0] scode;
    logic       alu_src;
    logic [1:0] cond;
  } ctrl_t;

  function automatic logic cond_met(input logic [1:0] cond, input logic zero,
                                    input logic carry);
    case (cond)
      2'b00:   return zero;
      2'b01:   return !zero;
      2'b10:   return carry;
      default: return !carry;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: classifies the latched IR and extracts the
// ALU/shift/branch fields, all relative to the instruction MSB.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int INSTR_W = 19
) (
  input  logic [INSTR_W-1:0] ir,
  output iclass_t            iclass,
  output ctrl_t              ctrl
);

  localparam int M = INSTR_W - 1;

  always_comb begin
    iclass = CL_ILLEGAL;
    ctrl   = '0;
    if (&ir) begin
      iclass = CL_HALT;
    end else if (ir[M:M-1] == OP_RTYPE || ir[M:M-1] == OP_IMM) begin
      iclass       = CL_ALU;
      ctrl.acode   = ir[M-2:M-4];
      ctrl.alu_src = ir[M-1];
    end else if (ir[M:M-2] == OP_SHIFT) begin
      iclass     = CL_SHIFT;
      ctrl.scode = ir[M-3:M-4];
    end else if (ir[M:M-2] == OP_MEM) begin
      if (ir[M-3:M-4] == MEM_LOAD)       iclass = CL_LOAD;
      else if (ir[M-3:M-4] == MEM_STORE) iclass = CL_STORE;
    end else if (ir[M:M-2] == OP_BRANCH) begin
      iclass    = CL_BRANCH;
      ctrl.cond = ir[M-3:M-4];
    end else if (ir[M:M-3] == OP_JUMP) begin
      iclass = ir[M-4] ? CL_JSB : CL_JUMP;
    end else if (ir[M:M-5] == OP_RET) begin
      iclass = CL_RET;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing with fetch and
// data-memory handshakes, a saturating return-stack depth tracker and a HALT state.
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 8,
  parameter int SD_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               instr_valid,
  input  logic               zero,
  input  logic               carry,
  input  logic               mem_ack,
  output logic               fetch_req,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               reg2_read_source,
  output logic               alu_src,
  output logic               mem_or_alu,
  output logic               is_shift,
  output logic               reg_write_signal,
  output logic               mem_req,
  output logic               mem_read_write,
  output logic               stack_push,
  output logic               stack_pop,
  output logic [2:0]         acode,
  output logic [1:0]         scode,
  output logic               halted,
  output logic               stack_fault,
  output logic               illegal
);

  state_t           state, state_nx;
  logic [INSTR_W-1:0] ir;
  logic [SD_W-1:0]  depth;
  logic             fault_q;
  iclass_t          iclass;
  ctrl_t            ctrl;
  logic             push_ok, pop_ok;

  instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .ir    (ir),
    .iclass(iclass),
    .ctrl  (ctrl)
  );

  assign push_ok = (depth != SD_W'(STACK_DEPTH));
  assign pop_ok  = (depth != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      ir      <= '0;
      depth   <= '0;
      fault_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && instr_valid) ir <= instruction;
      if (stack_push)     depth <= depth + SD_W'(1);
      else if (stack_pop) depth <= depth - SD_W'(1);
      if (stack_fault) fault_q <= 1'b1;
    end
  end

  // Outputs are forced low while rst is high so the reset cycle itself is quiet.
  always_comb begin
    state_nx         = state;
    fetch_req        = 1'b0;
    pc_write         = 1'b0;
    pc_src           = PC_NEXT;
    reg2_read_source = 1'b0;
    alu_src          = 1'b0;
    mem_or_alu       = 1'b0;
    is_shift         = 1'b0;
    reg_write_signal = 1'b0;
    mem_req          = 1'b0;
    mem_read_write   = 1'b0;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    acode            = '0;
    scode            = '0;
    halted           = 1'b0;
    stack_fault      = 1'b0;
    illegal          = 1'b0;
    if (!rst) begin
      stack_fault = fault_q;
      case (state)
        FETCH: begin
          fetch_req = 1'b1;
          if (instr_valid) state_nx = DECODE;
        end
        DECODE: begin
          case (iclass)
            CL_HALT:    state_nx = HALT;
            CL_ILLEGAL: begin
              illegal  = 1'b1;
              pc_write = 1'b1;
              state_nx = FETCH;
            end
            default:    state_nx = EXEC;
          endcase
        end
        EXEC: begin
          state_nx = FETCH;
          case (iclass)
            CL_ALU: begin
              acode            = ctrl.acode;
              alu_src          = ctrl.alu_src;
              mem_or_alu       = 1'b1;
              reg_write_signal = 1'b1;
              pc_write         = 1'b1;
            end
            CL_SHIFT: begin
              scode            = ctrl.scode;
              is_shift         = 1'b1;
              mem_or_alu       = 1'b1;
              reg_write_signal = 1'b1;
              pc_write         = 1'b1;
            end
            CL_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = cond_met(ctrl.cond, zero, carry) ? PC_TARGET : PC_NEXT;
            end
            CL_JUMP: begin
              pc_write = 1'b1;
              pc_src   = PC_TARGET;
            end
            CL_JSB: begin
              if (push_ok) begin
                stack_push = 1'b1;
                pc_write   = 1'b1;
                pc_src     = PC_TARGET;
              end else begin
                stack_fault = 1'b1;
                state_nx    = HALT;
              end
            end
            CL_RET: begin
              if (pop_ok) begin
                stack_pop = 1'b1;
                pc_write  = 1'b1;
                pc_src    = PC_STACK;
              end else begin
                stack_fault = 1'b1;
                state_nx    = HALT;
              end
            end
            CL_LOAD, CL_STORE: begin
              reg2_read_source = 1'b1;
              alu_src          = 1'b1;
              state_nx         = MEM;
            end
            default: state_nx = FETCH;
          endcase
        end
        MEM: begin
          mem_req          = 1'b1;
          reg2_read_source = 1'b1;
          alu_src          = 1'b1;
          mem_read_write   = (iclass == CL_STORE);
          if (mem_ack) begin
            if (iclass == CL_STORE) begin
              pc_write = 1'b1;
              state_nx = FETCH;
            end else begin
              state_nx = WB;
            end
          end
        end
        WB: begin
          reg_write_signal = 1'b1;
          pc_write         = 1'b1;
          state_nx         = FETCH;
        end
        HALT:    halted = 1'b1;
        default: state_nx = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction behavioural model producing the
// expected output vector every cycle, plus literal checks on latencies and key cycles.
module tb_multicycle_controller;

  localparam int IW = 19;
  localparam int SD = 2;
  localparam int M  = IW - 1;

  localparam int B_FETCH = 20, B_PCW = 19, B_PCS = 17, B_R2 = 16, B_ASRC = 15;
  localparam int B_MOA = 14, B_SH = 13, B_RW = 12, B_MREQ = 11, B_MRW = 10;
  localparam int B_PUSH = 9, B_POP = 8, B_AC = 5, B_SC = 3, B_HALT = 2, B_FAULT = 1, B_ILL = 0;

  logic clk, rst;
  logic [IW-1:0] instruction;
  logic instr_valid, zero, carry, mem_ack;
  logic fetch_req, pc_write, reg2_read_source, alu_src, mem_or_alu, is_shift;
  logic reg_write_signal, mem_req, mem_read_write, stack_push, stack_pop;
  logic halted, stack_fault, illegal;
  logic [1:0] pc_src, scode;
  logic [2:0] acode;

  multicycle_controller #(.INSTR_W(IW), .STACK_DEPTH(SD)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
    .zero(zero), .carry(carry), .mem_ack(mem_ack), .fetch_req(fetch_req),
    .pc_write(pc_write), .pc_src(pc_src), .reg2_read_source(reg2_read_source),
    .alu_src(alu_src), .mem_or_alu(mem_or_alu), .is_shift(is_shift),
    .reg_write_signal(reg_write_signal), .mem_req(mem_req),
    .mem_read_write(mem_read_write), .stack_push(stack_push), .stack_pop(stack_pop),
    .acode(acode), .scode(scode), .halted(halted), .stack_fault(stack_fault),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] actual, exp_v;
  assign actual = {fetch_req, pc_write, pc_src, reg2_read_source, alu_src, mem_or_alu,
                   is_shift, reg_write_signal, mem_req, mem_read_write, stack_push,
                   stack_pop, acode, scode, halted, stack_fault, illegal};

  bit exp_on = 1'b0;
  int n_checks = 0, n_fail = 0, cyc = 0;
  logic [20:0] hist [0:8191];

  int depth_m = 0;
  bit fault_m = 1'b0, halted_m = 1'b0;

  always @(negedge clk) begin
    if (exp_on) begin
      n_checks++;
      if (actual !== exp_v) begin
        n_fail++;
        $display("FAIL outputs cycle %0d: got %h expected %h (differing bits %h)",
                 cyc, actual, exp_v, actual ^ exp_v);
      end
    end
    if (cyc < 8192) hist[cyc] = actual;
    cyc++;
  end

  task automatic pin(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int hb(input int idx, input int bitpos);
    return int'(hist[idx][bitpos]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef enum {K_ALU, K_IMM, K_SHIFT, K_LOAD, K_STORE, K_BR, K_JMP, K_JSB, K_RET,
                K_HALT, K_ILL} kind_t;

  function automatic kind_t classify(input logic [IW-1:0] i);
    if (&i) return K_HALT;
    if (i[M:M-1] == 2'b00) return K_ALU;
    if (i[M:M-1] == 2'b01) return K_IMM;
    if (i[M:M-2] == 3'b110) return K_SHIFT;
    if (i[M:M-2] == 3'b100) begin
      if (i[M-3:M-4] == 2'b00) return K_LOAD;
      if (i[M-3:M-4] == 2'b01) return K_STORE;
      return K_ILL;
    end
    if (i[M:M-2] == 3'b101) return K_BR;
    if (i[M:M-3] == 4'b1110) return i[M-4] ? K_JSB : K_JMP;
    if (i[M:M-5] == 6'b111100) return K_RET;
    return K_ILL;
  endfunction

  function automatic logic [20:0] base();
    logic [20:0] v = '0;
    v[B_FAULT] = fault_m;
    return v;
  endfunction

  function automatic logic [IW-1:0] gen(input int k);
    logic [IW-1:0] r = IW'($urandom);
    case (k)
      0: r[M:M-1] = 2'b00;
      1: r[M:M-1] = 2'b01;
      2: r[M:M-2] = 3'b110;
      3: begin r[M:M-2] = 3'b100; r[M-3:M-4] = 2'($urandom_range(0, 1)); end
      4: r[M:M-2] = 3'b101;
      5: r[M:M-3] = 4'b1110;
      6: r[M:M-5] = 6'b111100;
      7: begin r[M:M-2] = 3'b100; r[M-3] = 1'b1; end
      8: begin r[M:M-5] = 6'b111101; end
      default: begin r = '1; if ($urandom_range(0, 3) != 0) r[$urandom_range(0, M-5)] = 1'b0; end
    endcase
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    instruction = IW'($urandom); instr_valid = 1'($urandom);
    zero = 1'($urandom); carry = 1'($urandom); mem_ack = 1'($urandom);
    exp_v = '0; exp_on = 1'b1;
    tick();
    rst = 1'b0;
    depth_m = 0; fault_m = 1'b0; halted_m = 1'b0;
  endtask

  task automatic halt_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      instruction = IW'($urandom); instr_valid = 1'($urandom);
      zero = 1'($urandom); carry = 1'($urandom); mem_ack = 1'($urandom);
      exp_v = base(); exp_v[B_HALT] = 1'b1;
      tick();
    end
  endtask

  task automatic run_instr(input logic [IW-1:0] ins, input int fwait, input int await_n,
                           input bit zv, input bit cv, input bit rst_in_mem,
                           output int cycles);
    kind_t k = classify(ins);
    bit taken;
    cycles = 0;
    for (int w = 0; w <= fwait; w++) begin
      instr_valid = (w == fwait);
      instruction = (w == fwait) ? ins : IW'($urandom);
      zero = 1'($urandom); carry = 1'($urandom); mem_ack = 1'($urandom);
      exp_v = base(); exp_v[B_FETCH] = 1'b1;
      cycles++; tick();
    end
    instruction = IW'($urandom); instr_valid = 1'($urandom);
    exp_v = base();
    if (k == K_ILL) begin
      exp_v[B_ILL] = 1'b1; exp_v[B_PCW] = 1'b1;
      cycles++; tick();
      return;
    end
    cycles++; tick();
    if (k == K_HALT) begin halted_m = 1'b1; return; end
    zero = zv; carry = cv; instr_valid = 1'($urandom);
    exp_v = base();
    case (k)
      K_ALU, K_IMM: begin
        exp_v[B_AC +: 3] = ins[M-2:M-4]; exp_v[B_ASRC] = (k == K_IMM);
        exp_v[B_MOA] = 1'b1; exp_v[B_RW] = 1'b1; exp_v[B_PCW] = 1'b1;
      end
      K_SHIFT: begin
        exp_v[B_SC +: 2] = ins[M-3:M-4]; exp_v[B_SH] = 1'b1;
        exp_v[B_MOA] = 1'b1; exp_v[B_RW] = 1'b1; exp_v[B_PCW] = 1'b1;
      end
      K_BR: begin
        case (ins[M-3:M-4])
          2'b00: taken = zv;
          2'b01: taken = !zv;
          2'b10: taken = cv;
          default: taken = !cv;
        endcase
        exp_v[B_PCW] = 1'b1; exp_v[B_PCS +: 2] = taken ? 2'b01 : 2'b00;
      end
      K_JMP: begin exp_v[B_PCW] = 1'b1; exp_v[B_PCS +: 2] = 2'b01; end
      K_JSB: begin
        if (depth_m < SD) begin
          exp_v[B_PUSH] = 1'b1; exp_v[B_PCW] = 1'b1; exp_v[B_PCS +: 2] = 2'b01;
          depth_m++;
        end else begin
          exp_v[B_FAULT] = 1'b1; fault_m = 1'b1; halted_m = 1'b1;
        end
      end
      K_RET: begin
        if (depth_m > 0) begin
          exp_v[B_POP] = 1'b1; exp_v[B_PCW] = 1'b1; exp_v[B_PCS +: 2] = 2'b10;
          depth_m--;
        end else begin
          exp_v[B_FAULT] = 1'b1; fault_m = 1'b1; halted_m = 1'b1;
        end
      end
      default: begin exp_v[B_R2] = 1'b1; exp_v[B_ASRC] = 1'b1; end
    endcase
    cycles++; tick();
    if (k != K_LOAD && k != K_STORE) return;
    for (int w = 0; w <= await_n; w++) begin
      zero = 1'($urandom); carry = 1'($urandom);
      if (rst_in_mem && w == 1) begin
        mem_ack = 1'b0;
        do_reset();
        return;
      end
      mem_ack = rst_in_mem ? 1'b0 : (w == await_n);
      exp_v = base();
      exp_v[B_MREQ] = 1'b1; exp_v[B_R2] = 1'b1; exp_v[B_ASRC] = 1'b1;
      exp_v[B_MRW] = (k == K_STORE);
      if (w == await_n && k == K_STORE) exp_v[B_PCW] = 1'b1;
      cycles++; tick();
    end
    mem_ack = 1'($urandom);
    if (k == K_LOAD) begin
      exp_v = base(); exp_v[B_RW] = 1'b1; exp_v[B_PCW] = 1'b1;
      cycles++; tick();
    end
  endtask

  initial begin
    int c, s, s2;
    logic [IW-1:0] ins;
    rst = 1'b1; instruction = '0; instr_valid = 1'b0;
    zero = 1'b0; carry = 1'b0; mem_ack = 1'b0;
    tick();
    do_reset();
    pin("reset_outputs_zero", int'(hist[cyc-1]), 0);

    // R-type add, fetch acknowledged immediately
    ins = gen(0); ins[M-2:M-4] = 3'b000;
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, c);
    pin("rtype_latency", c, 3);
    run_instr(gen(2), 0, 0, 1'b0, 1'b0, 1'b0, c);
    pin("rtype_exec_regwrite", hb(s + 2, B_RW), 1);
    pin("rtype_exec_mem_or_alu", hb(s + 2, B_MOA), 1);
    pin("rtype_exec_acode", int'(hist[s + 2][B_AC +: 3]), 0);
    pin("rtype_exec_pc_write", hb(s + 2, B_PCW), 1);
    pin("rtype_cycle4_fetch_req", hb(s + 3, B_FETCH), 1);

    // load with ack in the third MEM cycle
    ins = gen(3); ins[M-3:M-4] = 2'b00;
    s = cyc; run_instr(ins, 0, 2, 1'b0, 1'b0, 1'b0, c);
    pin("load_latency", c, 7);
    pin("load_mem_req_cycles", hb(s + 3, B_MREQ) + hb(s + 4, B_MREQ) + hb(s + 5, B_MREQ)
                                + hb(s + 6, B_MREQ), 3);
    pin("load_read_not_write", hb(s + 4, B_MRW), 0);
    pin("load_wb_regwrite", hb(s + 6, B_RW), 1);
    pin("load_wb_mem_or_alu", hb(s + 6, B_MOA), 0);

    ins = gen(3); ins[M-3:M-4] = 2'b01;
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, c);
    pin("store_latency", c, 4);
    pin("store_write", hb(s + 3, B_MRW), 1);

    // branch on carry set, taken then not taken
    ins = gen(4); ins[M-3:M-4] = 2'b10;
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b1, 1'b0, c);
    s2 = cyc; run_instr(ins, 0, 0, 1'b1, 1'b0, 1'b0, c);
    pin("branch_carry_taken_pc_src", int'(hist[s + 2][B_PCS +: 2]), 1);
    pin("branch_carry_not_taken_pc_src", int'(hist[s2 + 2][B_PCS +: 2]), 0);
    pin("branch_not_taken_pc_write", hb(s2 + 2, B_PCW), 1);

    // return-stack overflow on the third jsb
    do_reset();
    ins = gen(5); ins[M-4] = 1'b1;
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, c);
    s2 = cyc; run_instr(ins, 1, 0, 1'b0, 1'b0, 1'b0, c);
    pin("jsb1_push", hb(s + 2, B_PUSH), 1);
    pin("jsb2_push", hb(s2 + 3, B_PUSH), 1);
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, c);
    halt_cycles(3);
    pin("jsb3_fault", hb(s + 2, B_FAULT), 1);
    pin("jsb3_no_pc_write", hb(s + 2, B_PCW), 0);
    pin("jsb3_no_push", hb(s + 2, B_PUSH), 0);
    pin("jsb3_then_halted", hb(s + 3, B_HALT), 1);
    do_reset();

    // ret with empty stack
    s = cyc; run_instr(gen(6), 0, 0, 1'b0, 1'b0, 1'b0, c);
    halt_cycles(2);
    pin("ret_underflow_fault", hb(s + 2, B_FAULT), 1);
    pin("ret_underflow_no_pop", hb(s + 2, B_POP), 0);
    do_reset();

    // memory sub-op 11 is illegal
    ins = gen(3); ins[M-3:M-4] = 2'b11;
    s = cyc; run_instr(ins, 0, 0, 1'b0, 1'b0, 1'b0, c);
    pin("illegal_latency", c, 2);
    pin("illegal_pulse", hb(s + 1, B_ILL), 1);
    pin("illegal_pc_write", hb(s + 1, B_PCW), 1);
    pin("illegal_no_regwrite_memreq", hb(s + 1, B_RW) + hb(s + 1, B_MREQ), 0);

    // all-ones halts until reset
    s = cyc; run_instr('1, 0, 0, 1'b0, 1'b0, 1'b0, c);
    halt_cycles(4);
    pin("halt_sticky", hb(s + 5, B_HALT), 1);
    pin("halt_no_fetch", hb(s + 5, B_FETCH), 0);
    do_reset();
    pin("halt_reset_outputs_zero", int'(hist[cyc-1]), 0);

    // reset asserted in the middle of a MEM wait
    ins = gen(3); ins[M-3:M-4] = 2'b00;
    s = cyc; run_instr(ins, 0, 5, 1'b0, 1'b0, 1'b1, c);
    s2 = cyc; run_instr(gen(0), 0, 0, 1'b0, 1'b0, 1'b0, c);
    pin("mem_req_before_reset", hb(s + 3, B_MREQ), 1);
    pin("mem_req_dropped_after_reset", hb(s2, B_MREQ), 0);
    pin("fetch_after_mem_reset", hb(s2, B_FETCH), 1);

    for (int n = 0; n < 400; n++) begin
      int k;
      k = $urandom_range(0, 19);
      if (k > 9) k = (k < 14) ? 5 : (k < 17) ? 6 : k - 10;
      run_instr(gen(k), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 1'b0, c);
      if (halted_m) begin
        halt_cycles($urandom_range(1, 3));
        do_reset();
      end
    end

    exp_on = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
